// File: rtl/mac_sequencer_pkg.sv
// Shared definitions for the MAC sequencer: command/FSM encodings, datapath
// widths and the Horner range window used for the overflow flag.
package mac_sequencer_pkg;

  localparam int OP_W  = 8;
  localparam int ACC_W = 25;

  localparam logic signed [ACC_W-1:0] HORNER_MIN = -25'sd32768;
  localparam logic signed [ACC_W-1:0] HORNER_MAX = 25'sd32767;

  typedef enum logic {
    MODE_DOT    = 1'b0,
    MODE_HORNER = 1'b1
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SEED   = 3'd1,
    ST_BUBBLE = 3'd2,
    ST_ISSUE  = 3'd3,
    ST_DRAIN1 = 3'd4,
    ST_DRAIN2 = 3'd5,
    ST_DONE   = 3'd6
  } state_e;

  // True when a running Horner accumulator can still be scaled without wrapping.
  function automatic logic in_horner_range(input logic signed [ACC_W-1:0] v);
    return (v >= HORNER_MIN) && (v <= HORNER_MAX);
  endfunction

endpackage

// File: rtl/MAC_mac_unit.sv
// Two-register multiply-accumulate loop: product register, then accumulator.
// A new operation may issue only every second cycle so feedback is settled.
module MAC_mac_unit
  import mac_sequencer_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic signed [OP_W-1:0]  in_1,
  input  logic signed [OP_W-1:0]  in_2,
  input  logic                    mul_mux,
  input  logic                    add_mux,
  input  logic signed [OP_W-1:0]  in_add,
  output logic signed [ACC_W-1:0] mac_output
);

  logic signed [ACC_W-1:0] mul_a_s;
  logic signed [ACC_W-1:0] mul_b_s;
  logic signed [ACC_W-1:0] prod_r;
  logic signed [ACC_W-1:0] in_add_r;
  logic signed [ACC_W-1:0] acc_r;
  logic                    add_mux_r;

  // mul_mux feeds the accumulator back as multiplicand (Horner scaling)
  assign mul_a_s = mul_mux ? acc_r : ACC_W'(in_1);
  assign mul_b_s = ACC_W'(in_2);

  // Pipeline: stage 1 forms the product, stage 2 adds feedback or a fresh addend
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prod_r    <= {ACC_W{1'b0}};
      in_add_r  <= {ACC_W{1'b0}};
      add_mux_r <= 1'b0;
      acc_r     <= {ACC_W{1'b0}};
    end else begin
      prod_r    <= mul_a_s * mul_b_s;
      in_add_r  <= ACC_W'(in_add);
      add_mux_r <= add_mux;
      acc_r     <= prod_r + (add_mux_r ? acc_r : in_add_r);
    end
  end

  assign mac_output = acc_r;

endmodule

// File: rtl/mac_sequencer.sv
// Sequences dot-product or Horner-evaluation commands through a shared MAC,
// issuing one operand beat every second cycle and holding the result for handoff.
module mac_sequencer
  import mac_sequencer_pkg::*;
#(
  parameter int LEN_W = 8  // 1..10 keeps a full dot product inside 25 bits
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    mode,
  input  logic [LEN_W-1:0]        len,
  input  logic signed [OP_W-1:0]  bias,
  input  logic signed [OP_W-1:0]  x,
  output logic                    busy,
  input  logic                    op_valid,
  output logic                    op_ready,
  input  logic signed [OP_W-1:0]  op_a,
  input  logic signed [OP_W-1:0]  op_b,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic signed [ACC_W-1:0] result,
  output logic                    ovf
);

  localparam logic [LEN_W-1:0] LEN_ZERO = LEN_W'(1'b0);
  localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1'b1);

  state_e                  state_r, state_s;
  mode_e                   cmd_mode_r;
  logic [LEN_W-1:0]        cmd_len_r;
  logic signed [OP_W-1:0]  cmd_bias_r;
  logic signed [OP_W-1:0]  cmd_x_r;
  logic [LEN_W-1:0]        rem_r;
  logic                    busy_r;
  logic                    res_valid_r;
  logic signed [ACC_W-1:0] result_r;
  logic                    ovf_r;

  logic                    start_acc_s;
  logic                    xfer_s;
  logic                    last_s;
  logic signed [OP_W-1:0]  in_1_s, in_2_s, in_add_s;
  logic                    mul_mux_s, add_mux_s;
  logic signed [ACC_W-1:0] mac_output_s;

  assign start_acc_s = (state_r == ST_IDLE) && start;
  assign xfer_s      = (state_r == ST_ISSUE) && op_valid;
  assign last_s      = (rem_r == LEN_ONE);
  assign op_ready    = (state_r == ST_ISSUE);

  // Next-state decode; a stalled ISSUE falls back to BUBBLE to preserve slot parity
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE:   if (start) state_s = ST_SEED; else state_s = ST_IDLE;
      ST_SEED:   if (cmd_len_r == LEN_ZERO) state_s = ST_DRAIN1; else state_s = ST_BUBBLE;
      ST_BUBBLE: state_s = ST_ISSUE;
      ST_ISSUE:  if (xfer_s && last_s) state_s = ST_DRAIN1; else state_s = ST_BUBBLE;
      ST_DRAIN1: state_s = ST_DRAIN2;
      ST_DRAIN2: state_s = ST_DONE;
      ST_DONE:   if (res_ready) state_s = ST_IDLE; else state_s = ST_DONE;
      default:   state_s = ST_IDLE;
    endcase
  end

  // MAC control decode; anything that is not a seed or a live beat holds the accumulator
  always_comb begin
    in_1_s    = 8'sd0;
    in_2_s    = 8'sd0;
    mul_mux_s = 1'b0;
    add_mux_s = 1'b1;
    in_add_s  = 8'sd0;
    case (state_r)
      ST_SEED: begin
        add_mux_s = 1'b0;
        in_add_s  = (cmd_mode_r == MODE_DOT) ? cmd_bias_r : 8'sd0;
      end
      ST_ISSUE: begin
        if (xfer_s) begin
          if (cmd_mode_r == MODE_DOT) begin
            in_1_s = op_a;
            in_2_s = op_b;
          end else begin
            in_2_s    = cmd_x_r;
            mul_mux_s = 1'b1;
            add_mux_s = 1'b0;
            in_add_s  = op_a;
          end
        end else begin
          add_mux_s = 1'b1;
        end
      end
      default: add_mux_s = 1'b1;
    endcase
  end

  // Control state, command capture, beat counting and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      cmd_mode_r  <= MODE_DOT;
      cmd_len_r   <= LEN_ZERO;
      cmd_bias_r  <= 8'sd0;
      cmd_x_r     <= 8'sd0;
      rem_r       <= LEN_ZERO;
      busy_r      <= 1'b0;
      res_valid_r <= 1'b0;
      result_r    <= {ACC_W{1'b0}};
      ovf_r       <= 1'b0;
    end else begin
      state_r     <= state_s;
      busy_r      <= (state_s != ST_IDLE);
      res_valid_r <= (state_s == ST_DONE);
      if (start_acc_s) begin
        cmd_mode_r <= mode_e'(mode);
        cmd_len_r  <= len;
        cmd_bias_r <= bias;
        cmd_x_r    <= x;
        rem_r      <= len;
      end else if (xfer_s) begin
        rem_r <= rem_r - LEN_ONE;
      end
      if (state_r == ST_DRAIN2) begin
        result_r <= mac_output_s;
      end
      // The multiplicand of a Horner beat must fit 16 bits or the product can wrap
      if (start_acc_s) begin
        ovf_r <= 1'b0;
      end else if (xfer_s && (cmd_mode_r == MODE_HORNER) && !in_horner_range(mac_output_s)) begin
        ovf_r <= 1'b1;
      end
    end
  end

  MAC_mac_unit u_mac_unit (
    .clk        (clk),
    .reset      (reset),
    .in_1       (in_1_s),
    .in_2       (in_2_s),
    .mul_mux    (mul_mux_s),
    .add_mux    (add_mux_s),
    .in_add     (in_add_s),
    .mac_output (mac_output_s)
  );

  assign busy      = busy_r;
  assign res_valid = res_valid_r;
  assign result    = result_r;
  assign ovf       = ovf_r;

endmodule

// File: tb/tb_mac_sequencer.sv
// Bench for mac_sequencer: a cycle-schedule reference model checked every cycle,
// directed scenarios with literal expectations, then a randomized soak.
module tb_mac_sequencer;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              mode = 1'b0;
  logic [7:0]        len = 8'd0;
  logic signed [7:0] bias = 8'sd0;
  logic signed [7:0] x = 8'sd0;
  logic              busy;
  logic              op_valid = 1'b0;
  logic              op_ready;
  logic signed [7:0] op_a = 8'sd0;
  logic signed [7:0] op_b = 8'sd0;
  logic              res_valid;
  logic              res_ready = 1'b0;
  logic signed [24:0] result;
  logic              ovf;

  int n_checks = 0;
  int n_err = 0;
  int cyc = 0;

  mac_sequencer #(.LEN_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .len(len),
    .bias(bias), .x(x), .busy(busy), .op_valid(op_valid), .op_ready(op_ready),
    .op_a(op_a), .op_b(op_b), .res_valid(res_valid), .res_ready(res_ready),
    .result(result), .ovf(ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model (operation schedule + arithmetic) -------
  // phase 0 = idle, 1 = collecting beats, 2 = waiting for result handoff
  int     m_phase = 0;
  int     m_slot, m_left, m_done;
  bit     m_mode;
  longint m_acc, m_x;
  bit     m_ovf = 0;
  longint m_out_res = 0;
  bit     m_out_known = 1;

  always @(negedge clk) begin
    if (reset) begin
      check("rst_busy", busy, 0);
      check("rst_op_ready", op_ready, 0);
      check("rst_res_valid", res_valid, 0);
      check("rst_result", result, 0);
      check("rst_ovf", ovf, 0);
      m_phase = 0; m_ovf = 0; m_out_res = 0; m_out_known = 1;
    end else begin
      check("busy", busy, m_phase != 0);
      check("op_ready", op_ready, (m_phase == 1) && (cyc == m_slot));
      check("res_valid", res_valid, (m_phase == 2) && (cyc >= m_done));
      if (m_out_known) check("result", result, m_out_res);
      check("ovf", ovf, m_ovf);
      // advance the model by what the coming clock edge does
      case (m_phase)
        0: if (start) begin
          m_mode = mode; m_x = x; m_left = len; m_ovf = 0;
          m_acc = mode ? 0 : longint'(bias);
          if (len == 8'd0) begin m_phase = 2; m_done = cyc + 4; end
          else begin m_phase = 1; m_slot = cyc + 3; end
        end
        1: if (cyc == m_slot) begin
          if (op_valid) begin
            if (!m_mode) m_acc = m_acc + longint'(op_a) * longint'(op_b);
            else begin
              if (m_acc < -32768 || m_acc > 32767) m_ovf = 1;
              m_acc = m_acc * m_x + longint'(op_a);
            end
            m_left--;
            if (m_left == 0) begin m_phase = 2; m_done = cyc + 3; end
            else m_slot = cyc + 2;
          end else m_slot = cyc + 2;
        end
        2: if (cyc >= m_done && res_ready) m_phase = 0;
        default: m_phase = 0;
      endcase
      if (m_phase == 2 && cyc + 1 == m_done) begin
        m_out_res = m_acc; m_out_known = !m_ovf;
      end
    end
  end

  // ---------------- directed driver ----------------------------------------
  int da[0:299];
  int db[0:299];

  task automatic run_dir(input bit md, input int n, input int bs, input int xx,
                         input int stall_at, input int gap, input bit poke,
                         output longint res, output int lat, output bit ov,
                         output int last_x, output bit ready_pair);
    int s, idx, quiet;
    bit xf, prev_rdy;
    start = 1'b1; mode = md; len = 8'(n); bias = 8'(bs); x = 8'(xx);
    op_valid = 1'b0; res_ready = 1'b1;
    s = cyc; idx = 0; quiet = 0; lat = -1; res = 0; ov = 0; last_x = -1;
    ready_pair = 0; prev_rdy = 0;
    @(posedge clk); #1;
    for (int t = 0; t < 2000; t++) begin
      start = poke && (t == 4);
      if (start) begin mode = 1'b0; len = 8'd1; end
      else begin mode = md; len = 8'(n); end
      op_valid = (idx < n) && !(idx == stall_at && quiet < gap);
      op_a = (idx < n) ? 8'(da[idx]) : 8'sd0;
      op_b = (idx < n) ? 8'(db[idx]) : 8'sd0;
      @(negedge clk);
      xf = op_ready && op_valid;
      if (xf) last_x = cyc - s;
      if (op_ready && prev_rdy) ready_pair = 1;
      prev_rdy = op_ready;
      if (res_valid) begin
        lat = cyc - s; res = result; ov = ovf;
        break;
      end
      @(posedge clk); #1;
      if (xf) begin idx++; quiet = 0; end else quiet++;
    end
    @(posedge clk); #1;
    op_valid = 1'b0; start = 1'b0;
  endtask

  longint res;
  int     lat, lx;
  bit     ov, rp, seen;
  logic [31:0] r;

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;

    // dot, N=3, bias=5
    da[0] = 1; da[1] = 2; da[2] = 3; db[0] = 4; db[1] = 5; db[2] = 6;
    run_dir(1'b0, 3, 5, 0, -1, 0, 1'b0, res, lat, ov, lx, rp);
    check("dot3_result", res, 37); check("dot3_latency", lat, 10); check("dot3_ovf", ov, 0);

    // Horner x=2, coeffs 3,0,-1
    da[0] = 3; da[1] = 0; da[2] = -1;
    run_dir(1'b1, 3, 0, 2, -1, 0, 1'b0, res, lat, ov, lx, rp);
    check("horner3_result", res, 11); check("horner3_latency", lat, 10);

    // stall before beat 2
    da[0] = 10; da[1] = -4; db[0] = 3; db[1] = 5;
    run_dir(1'b0, 2, 0, 0, 1, 3, 1'b0, res, lat, ov, lx, rp);
    check("stall_result", res, 10); check("stall_beat2_cycle", lx, 7);
    check("stall_latency", lat, 10); check("stall_ready_b2b", rp, 0);

    // longest dot with extreme operands
    for (int i = 0; i < 255; i++) begin da[i] = -128; db[i] = -128; end
    run_dir(1'b0, 255, -128, 0, -1, 0, 1'b0, res, lat, ov, lx, rp);
    check("dot255_result", res, 4177792); check("dot255_ovf", ov, 0);
    check("dot255_latency", lat, 514);

    // Horner overflow, with a start poked while busy
    for (int i = 0; i < 4; i++) da[i] = 127;
    run_dir(1'b1, 4, 0, 127, -1, 0, 1'b1, res, lat, ov, lx, rp);
    check("horner_ovf_flag", ov, 1); check("horner_ovf_latency", lat, 12);
    @(negedge clk); check("poke_ignored_idle", busy, 0);
    @(posedge clk); #1;

    // N=0 dot
    run_dir(1'b0, 0, -7, 0, -1, 0, 1'b0, res, lat, ov, lx, rp);
    check("n0_result", res, -7); check("n0_latency", lat, 4);

    // reset in the middle of an ISSUE slot
    start = 1'b1; mode = 1'b0; len = 8'd3; bias = 8'sd9; op_valid = 1'b1;
    op_a = 8'sd4; op_b = 8'sd4;
    @(posedge clk); #1 start = 1'b0;
    seen = 0;
    for (int t = 0; t < 20 && !seen; t++) begin @(negedge clk); seen = op_ready; end
    check("issue_reached", seen, 1);
    #2 reset = 1'b1;
    @(negedge clk); #1;
    check("midrst_busy", busy, 0); check("midrst_result", result, 0);
    check("midrst_ovf", ovf, 0); check("midrst_res_valid", res_valid, 0);
    @(posedge clk); #1 reset = 1'b0; op_valid = 1'b0;
    da[0] = 2; db[0] = 3;
    run_dir(1'b0, 1, 1, 0, -1, 0, 1'b0, res, lat, ov, lx, rp);
    check("after_rst_result", res, 7); check("after_rst_latency", lat, 6);

    // randomized soak against the model
    for (int c = 0; c < 4000; c++) begin
      r = $urandom;
      start = (r[1:0] == 2'd0);
      mode = r[2];
      len = 8'($urandom_range(0, 6));
      bias = r[15:8];
      x = r[3] ? 8'($urandom_range(0, 4) - 2) : r[23:16];
      op_valid = (r[5:4] != 2'd0);
      r = $urandom;
      op_a = r[7:0]; op_b = r[15:8];
      res_ready = r[16];
      reset = ($urandom_range(0, 399) == 0);
      @(posedge clk); #1;
    end
    reset = 1'b0; start = 1'b0; op_valid = 1'b1; res_ready = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/mac_sequencer.md
MAC_SEQUENCER -- requirements
Module: mac_sequencer

Interface
REQ-001 Parameter LEN_W, default 8: width of the term-count field; SHALL be limited to 1..10 so dot products cannot overflow 25 bits.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 start  in  1  command strobe; sampled only in IDLE.
REQ-005 mode  in  1  0 = dot product, 1 = Horner polynomial evaluation.
REQ-006 len  in  LEN_W  number of operand beats N; 0 legal.
REQ-007 bias  in  8 signed  dot-mode initial accumulator value.
REQ-008 x  in  8 signed  Horner evaluation point.
REQ-009 busy  out  1  high from the cycle after start is accepted until the result is consumed.
REQ-010 op_valid / op_ready  in / out  1  operand beat handshake; a beat transfers when both are high.
REQ-011 op_a, op_b  in  8 signed  dot: multiplicand pair; Horner: op_a = coefficient (highest order first), op_b ignored.
REQ-012 res_valid / res_ready  out / in  1  result handshake.
REQ-013 result  out  25 signed  final accumulator value.
REQ-014 ovf  out  1  sticky per-operation Horner range flag.

Function
REQ-015 Command fields (mode, len, bias, x) SHALL be registered when start is accepted in IDLE; start is ignored while busy.
REQ-016 FSM states SHALL be IDLE, SEED, BUBBLE, ISSUE, DRAIN1, DRAIN2, DONE.
REQ-017 Transitions: IDLE->SEED on start; SEED->BUBBLE, or SEED->DRAIN1 when N=0; BUBBLE->ISSUE; ISSUE->DRAIN1 on the final beat transfer, ISSUE->BUBBLE on any other transfer or when op_valid is low; DRAIN1->DRAIN2->DONE; DONE->IDLE on res_ready.
REQ-018 The MAC feedback loop has two registers; an issue SHALL occur only every second cycle (SEED/ISSUE slots), and stalls SHALL be absorbed in 2-cycle BUBBLE/ISSUE pairs to keep slot parity.
REQ-019 op_ready SHALL be high only in ISSUE, combinationally, with no dependence on op_valid.
REQ-020 MAC controls SHALL be a combinational decode of state.
- SEED: in_1=0, in_2=0, mul_mux=0, add_mux=0, in_add = bias (dot) or 0 (Horner).
- ISSUE with transfer, dot: in_1=op_a, in_2=op_b, mul_mux=0, add_mux=1.
- ISSUE with transfer, Horner: in_2=x, mul_mux=1, add_mux=0, in_add=op_a.
- All other states, or no transfer: in_1=0, in_2=0, mul_mux=0, add_mux=1, in_add=0 (hold).
REQ-021 In DRAIN2, result SHALL load from mac_output, and res_valid SHALL rise the next cycle; result and res_valid stay stable in DONE until res_ready.
REQ-022 Latency with no stalls: start sampled at cycle S gives beat k accepted at S+1+2k and res_valid at S+4+2N; each stalled slot adds 2 cycles.
REQ-023 N=0: result = bias (dot) or 0 (Horner).
REQ-024 ovf SHALL clear on start and set when a Horner beat transfers while mac_output is outside [-32768, 32767]; result is then undefined; ovf is never set in dot mode.

Reset
REQ-025 reset SHALL force IDLE asynchronously, including mid-operation, and clear the MAC accumulators.
REQ-026 Reset values: busy=0, op_ready=0, res_valid=0, result=0, ovf=0, command registers=0.
REQ-027 After reset release, the next accepted start SHALL complete correctly with no residue from the aborted operation.

Structure
REQ-028 A shared package SHALL hold the mode encoding, FSM state encoding, MAC operand width (8), MAC output width (25) and the Horner range limits.
REQ-029 The block SHALL instantiate exactly one sub-module, MAC_mac_unit, sharing clk and reset; no other arithmetic is permitted.

Verification
REQ-030 Dot, N=3, bias=5, a={1,2,3}, b={4,5,6}, op_valid held high -> result=37, res_valid at S+10, ovf=0.
REQ-031 Horner, x=2, N=3, coeffs={3,0,-1} -> result=11 at S+10.
REQ-032 Dot, N=2, a={10,-4}, b={3,5}, bias=0, op_valid low 3 cycles before beat 2 -> result=10; beat 2 accepted at S+7; op_ready never high on consecutive cycles.
REQ-033 Dot, N=255, all a=b=-128, bias=-128 -> result=4177792, ovf=0.
REQ-034 Horner, x=127, N=4, coeffs all 127 -> ovf=1 at the end of the operation; start while busy is ignored.
REQ-035 Dot, N=0, bias=-7 -> result=-7 at S+4; then reset pulsed during ISSUE of a second operation -> all outputs 0; following dot N=1, a=2, b=3, bias=1 -> result=7.
